// File: rtl/ls_dma.sv
// ---------------------------------------------------------------------------
// ls_dma : block mover between a 128-bit local store (LS) and two streams.
//
// A command gives a direction, a quadword-aligned LS start address and a
// quadword count. A store (cmd_dir=0) takes quadwords from the in stream
// and writes them to the LS. A load (cmd_dir=1) reads the LS and sends the
// quadwords out on the out stream. Every transfer ends with a one-cycle
// FIN state that pulses done.
//
// Ports
//   clk                     system clock, rising edge
//   rst                     asynchronous reset, active low
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_dir                 0 = store (stream -> LS), 1 = load (LS -> stream)
//   cmd_addr[17:0]          LS start byte address, low nibble ignored
//   cmd_qw[14:0]            quadword count, 0..16384
//   in_valid/in_ready       store data stream handshake
//   in_data[127:0]          store data
//   out_valid/out_ready     load data stream handshake
//   out_data[127:0]         load data (head of the read buffer)
//   ls_ce/ls_we             LS chip enable / write enable
//   ls_addr[17:0]           LS byte address, low nibble always zero
//   ls_wdata[127:0]         LS write data
//   ls_rdata[127:0]         LS read data, valid the cycle after a read
//   busy                    high whenever a transfer is in progress
//   done                    one-cycle pulse when a transfer completes
// ---------------------------------------------------------------------------
module ls_dma (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_dir,
  input  logic [17:0]  cmd_addr,
  input  logic [14:0]  cmd_qw,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         ls_ce,
  output logic         ls_we,
  output logic [17:0]  ls_addr,
  output logic [127:0] ls_wdata,
  input  logic [127:0] ls_rdata,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // One quadword in bytes; addr_r wraps naturally at 2^18.
  localparam logic [17:0] QW_STEP = 18'd16;

  // Control state
  state_t        state_r;
  logic [17:0]   addr_r;        // next LS address to access
  logic [14:0]   rem_r;         // quadwords still to hand over on the stream side
  logic [14:0]   issue_rem_r;   // load only: reads still to issue
  logic          cmd_ready_r;
  logic          busy_r;
  logic          done_r;
  logic          in_ready_r;

  // Load read path: one read can be in flight, two entries of buffering
  logic          inflight_r;
  logic [127:0]  fifo0_r;
  logic [127:0]  fifo1_r;
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    occ_r;

  // Per-cycle decisions
  logic          load_st_s;
  logic          store_hs_s;
  logic          pop_s;
  logic          rd_issue_s;
  logic [2:0]    level_s;

  // The low address nibble of a command is deliberately discarded.
  logic          unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^cmd_addr[3:0];

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign in_ready  = in_ready_r;

  // Stream handshakes and the load read-issue decision for this cycle.
  always_comb begin
    load_st_s  = (state_r == ST_LOAD);
    store_hs_s = in_valid & in_ready_r;
    out_valid  = load_st_s & (occ_r != 2'd0);
    pop_s      = out_valid & out_ready;
    level_s    = {1'b0, occ_r} + {2'b00, inflight_r};
    // A new read lands two edges from now. It is safe when the buffer plus
    // the read already in flight leaves a slot, counting an entry that is
    // popped this same cycle as free; that keeps one quadword per cycle.
    if (load_st_s && (issue_rem_r != 15'd0)) begin
      rd_issue_s = (level_s < 3'd2) || ((level_s == 3'd2) && pop_s);
    end else begin
      rd_issue_s = 1'b0;
    end
  end

  // Head of the read buffer drives the out stream.
  always_comb begin
    if (rd_ptr_r) begin
      out_data = fifo1_r;
    end else begin
      out_data = fifo0_r;
    end
  end

  // LS port: a write on each store handshake, a read on each issue, else idle.
  always_comb begin
    ls_ce    = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = 18'd0;
    ls_wdata = 128'd0;
    if (store_hs_s) begin
      ls_ce    = 1'b1;
      ls_we    = 1'b1;
      ls_addr  = addr_r;
      ls_wdata = in_data;
    end else if (rd_issue_s) begin
      ls_ce    = 1'b1;
      ls_we    = 1'b0;
      ls_addr  = addr_r;
    end else begin
      ls_ce    = 1'b0;
      ls_we    = 1'b0;
    end
  end

  // Transfer FSM with its registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= 18'd0;
      rem_r       <= 15'd0;
      issue_rem_r <= 15'd0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_r      <= {cmd_addr[17:4], 4'h0};
            rem_r       <= cmd_qw;
            issue_rem_r <= cmd_qw;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (cmd_qw == 15'd0) begin
              state_r <= ST_FIN;
              done_r  <= 1'b1;
            end else if (!cmd_dir) begin
              state_r    <= ST_STORE;
              in_ready_r <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_STORE: begin
          if (store_hs_s) begin
            addr_r <= addr_r + QW_STEP;
            rem_r  <= rem_r - 15'd1;
            if (rem_r == 15'd1) begin
              state_r    <= ST_FIN;
              in_ready_r <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              state_r <= ST_STORE;
            end
          end else begin
            state_r <= ST_STORE;
          end
        end

        ST_LOAD: begin
          if (rd_issue_s) begin
            addr_r      <= addr_r + QW_STEP;
            issue_rem_r <= issue_rem_r - 15'd1;
          end else begin
            issue_rem_r <= issue_rem_r;
          end
          // The transfer ends on the out-stream handshake of the last word.
          if (pop_s) begin
            rem_r <= rem_r - 15'd1;
            if (rem_r == 15'd1) begin
              state_r <= ST_FIN;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end

        ST_FIN: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end

        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Load read buffer: capture the LS data one cycle after issue, pop on the
  // out handshake; capture and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= 1'b0;
      fifo0_r    <= 128'd0;
      fifo1_r    <= 128'd0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      occ_r      <= 2'd0;
    end else begin
      inflight_r <= rd_issue_s;
      if (inflight_r) begin
        if (wr_ptr_r) begin
          fifo1_r <= ls_rdata;
        end else begin
          fifo0_r <= ls_rdata;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      occ_r <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

endmodule
